// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction fetch sequencer for a single-cycle (combinational) read imem.
//   The block owns the PC and presents its word address to imem. Each cycle it
//   captures {pc, imem_dout} into a 2-entry FIFO that feeds decode over a
//   valid/ready handshake. Branch/jump redirects flush the FIFO and reload the
//   PC. A PC beyond the end of imem raises a sticky fault; the fault clears on
//   the next redirect.
//
// Ports
//   clk, reset_b        : clock (rising edge) / asynchronous active-low reset
//   start               : one-cycle pulse, IDLE -> RUN
//   imem_addr           : word address to imem (pc[IMEM_ADDR_WIDTH+1:2])
//   imem_dout           : instruction read for imem_addr in the same cycle
//   redirect_valid/_pc  : taken branch/jump and its target (bits [1:0] ignored)
//   out_valid/ready     : handshake to decode for the FIFO head
//   out_inst/out_pc     : head instruction and its PC (0 when empty)
//   fault               : sticky out-of-range fetch indication
//   fetch_cnt           : instructions pushed into the FIFO since reset

module imem_fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH      = 1024,
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       start,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic                       fault,
  output logic [31:0]                fetch_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] head_q, head_d;   // {pc, inst}
  logic [63:0] tail_q, tail_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic        in_range;
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] target;
  logic [63:0] new_entry;

  // Word index compared against the depth; for a power-of-two depth this is
  // the same as requiring pc[31:IMEM_ADDR_WIDTH+2] to be zero.
  assign in_range  = ({2'b00, pc_q[31:2]} < DEPTH_W);
  assign target    = redirect_pc & ~32'h3;
  assign new_entry = {pc_q, imem_dout};

  assign imem_addr = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign out_valid = (cnt_q != 2'd0);
  assign out_inst  = out_valid ? head_q[31:0]  : '0;
  assign out_pc    = out_valid ? head_q[63:32] : '0;
  assign fault     = fault_q;
  assign fetch_cnt = fetch_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) pc_d = target;
        if (start)          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // A head handshake coinciding with a redirect is not a transfer.
          flush = 1'b1;
          pc_d  = target;
        end else begin
          pop = out_valid & out_ready;
          if (!in_range) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            push = (cnt_q != 2'd2) | pop;
          end
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = target;
          fault_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          pop = out_valid & out_ready;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = new_entry;
          else               tail_d = new_entry;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            head_d = new_entry;
          end else begin
            head_d = tail_q;
            tail_d = new_entry;
          end
        end
        default: ;
      endcase
    end

    if (push) begin
      pc_d        = pc_q + 32'd4;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: behavioural imem, scoreboard of expected
// {pc, inst} transfers consumed by a negedge monitor, scenario tasks with
// inline checks.

module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start;
  logic [9:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr];

  imem_fetch_ctrl #(
    .IMEM_DEPTH      (1024),
    .IMEM_ADDR_WIDTH (10),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  // Scoreboard consumer: a handshake seen here transfers at the next edge.
  always @(negedge clk) begin
    if (reset_b && out_valid && out_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_transfer: got pc=%h inst=%h, required no transfer", out_pc, out_inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_pc !== mon_e.pc || out_inst !== mon_e.inst) begin
          failures++;
          $display("FAIL transfer_order: got pc=%h inst=%h, required pc=%h inst=%h",
                   out_pc, out_inst, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_b        = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_b = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem[pc[11:2]];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    #1;
    checks++;
    if ({out_valid, fault, out_pc, out_inst, fetch_cnt, imem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b fault=%b pc=%h inst=%h cnt=%0d addr=%0d, required all zero",
               out_valid, fault, out_pc, out_inst, fetch_cnt, imem_addr);
    end
    apply_reset();
    tick();
    checks++;
    if (out_valid !== 1'b0 || fetch_cnt !== 32'd0) begin
      failures++;
      $display("FAIL idle_no_fetch: got valid=%b cnt=%0d, required 0 0", out_valid, fetch_cnt);
    end
  endtask

  task automatic test_start_stream();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    pulse_start();
    repeat (4) tick();
    checks++;
    if (fetch_cnt !== 32'd4 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL stream_cnt: got cnt=%0d pending=%0d, required cnt=4 pending=1", fetch_cnt, exp_q.size());
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_throughput: got pending=%0d, required 0", exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          failures++;
          $display("FAIL bp_hold: got valid=%b pc=%h, required 1 00000000", out_valid, out_pc);
        end
      end
    end
    checks++;
    if (fetch_cnt !== 32'd2 || imem_addr !== 10'd2 || out_inst !== mem[0]) begin
      failures++;
      $display("FAIL bp_full: got cnt=%0d addr=%0d inst=%h, required 2 2 %h", fetch_cnt, imem_addr, out_inst, mem[0]);
    end
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: got pending=%0d, required 0", exp_q.size());
    end
    checks++;
    if (fetch_cnt !== 32'd5 || out_pc !== 32'hC) begin
      failures++;
      $display("FAIL bp_after: got cnt=%0d pc=%h, required 5 0000000c", fetch_cnt, out_pc);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    out_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || fetch_cnt !== 32'd2 || imem_addr !== 10'd16) begin
      failures++;
      $display("FAIL redirect_flush: got valid=%b pc=%h inst=%h cnt=%0d addr=%0d, required 0 0 0 2 16",
               out_valid, out_pc, out_inst, fetch_cnt, imem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== mem[16] || fetch_cnt !== 32'd3) begin
      failures++;
      $display("FAIL redirect_target: got valid=%b pc=%h inst=%h cnt=%0d, required 1 00000040 %h 3",
               out_valid, out_pc, out_inst, fetch_cnt, mem[16]);
    end
    push_exp(32'h40);
    push_exp(32'h44);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL redirect_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_fault();
    apply_reset();
    out_ready = 1'b0;
    pulse_start();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 10'd1023) begin
      failures++;
      $display("FAIL fault_addr: got %0d, required 1023", imem_addr);
    end
    tick();
    checks++;
    if (fault !== 1'b0 || out_pc !== 32'hFFC || fetch_cnt !== 32'd1) begin
      failures++;
      $display("FAIL fault_last: got fault=%b pc=%h cnt=%0d, required 0 00000ffc 1", fault, out_pc, fetch_cnt);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL fault_raise: got fault=%b addr=%0d, required 1 0", fault, imem_addr);
    end
    repeat (2) tick();
    checks++;
    if (fault !== 1'b1 || fetch_cnt !== 32'd1 || out_pc !== 32'hFFC || out_inst !== mem[1023]) begin
      failures++;
      $display("FAIL fault_sticky: got fault=%b cnt=%0d pc=%h inst=%h, required 1 1 00000ffc %h",
               fault, fetch_cnt, out_pc, out_inst, mem[1023]);
    end
    push_exp(32'hFFC);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_drain: got pending=%0d valid=%b fault=%b, required 0 0 1", exp_q.size(), out_valid, fault);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: got fault=%b valid=%b, required 0 0", fault, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_inst !== mem[4]) begin
      failures++;
      $display("FAIL fault_resume: got valid=%b pc=%h inst=%h, required 1 00000010 %h", out_valid, out_pc, out_inst, mem[4]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    #2;
    reset_b = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || fetch_cnt !== 32'd0 || out_pc !== 32'h0 || imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b fault=%b cnt=%0d pc=%h addr=%0d, required all zero",
               out_valid, fault, fetch_cnt, out_pc, imem_addr);
    end
    #1;
    reset_b = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || fetch_cnt !== 32'd0) begin
      failures++;
      $display("FAIL async_needs_start: got valid=%b cnt=%0d, required 0 0", out_valid, fetch_cnt);
    end
    pulse_start();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== mem[0]) begin
      failures++;
      $display("FAIL async_restart: got valid=%b pc=%h inst=%h, required 1 00000000 %h", out_valid, out_pc, out_inst, mem[0]);
    end
  endtask

  task automatic test_idle_redirect();
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0022;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 10'd8) begin
      failures++;
      $display("FAIL idle_redirect_addr: got %0d, required 8", imem_addr);
    end
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || fetch_cnt !== 32'd0) begin
      failures++;
      $display("FAIL idle_redirect_nofetch: got valid=%b cnt=%0d, required 0 0", out_valid, fetch_cnt);
    end
    pulse_start();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_inst !== mem[8]) begin
      failures++;
      $display("FAIL idle_redirect_first: got valid=%b pc=%h inst=%h, required 1 00000020 %h", out_valid, out_pc, out_inst, mem[8]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {12'hA5C, 20'(i * 7 + 3)};
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;
    reset_b        = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    test_reset();
    test_start_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_async_reset();
    test_idle_redirect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion, required completion within 200000");
    $fatal(1, "timeout");
  end

endmodule
